contador: RTL and testbench
===========================

Name: contador

Overview:
- Synchronous up/down binary counter with parallel load, count enable and direction control.
- Generic sequencing/timing primitive used wherever a loadable, pausable, bidirectional count is needed.
- Single clock domain. Output is taken directly from the state register.

Parameters:
- WIDTH, 4, bit width of data_in, data_out and the internal count register.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset. Low clears the count immediately; release is sampled on the following clk edges.
- data_in  input  WIDTH  parallel load value.
- load  input  1  synchronous load request, active-high.
- con  input  1  count enable, active-high. 0 pauses the counter.
- cup  input  1  count direction: 1 counts up, 0 counts down.
- data_out  output  WIDTH  current count value, registered.

Behaviour:
- Reset: while rst=0, data_out=0 asynchronously, independent of clk. The first count occurs on the first rising clk edge with rst=1.
- Priority at each rising clk edge, with rst=1:
  - 1) load=1: data_out <= data_in. Applies regardless of con and cup.
  - 2) else con=1 and cup=1: data_out <= data_out+1.
  - 3) else con=1 and cup=0: data_out <= data_out-1.
  - 4) else (con=0): data_out holds.
- Arithmetic: unsigned, modulo 2^WIDTH.
  - Up-count wrap: 2^WIDTH-1 -> 0 (4'hF -> 4'h0).
  - Down-count wrap: 0 -> 2^WIDTH-1 (4'h0 -> 4'hF).
  - No carry or borrow output.
- Latency: one clock. Inputs sampled at edge N appear on data_out right after edge N.
- Simultaneous load and con=1: load wins; no increment is applied in that cycle.
- Direction or enable changes take effect at the next edge; no glitch or extra step.
- Reset asserted mid-count: data_out goes to 0 at once. Counting resumes from 0 after release.
- No combinational path from any input to data_out.
- Registers are X-free after the first reset.

Test Plan:
- Reset then up: rst=0 with data_in=1, load=0, con=1, cup=1; then rst=1 -> data_out=0 during reset, then 1,2,...,8 on 8 successive edges.
- Pause: from 8, con=0 for 3 cycles -> data_out stays 8. Then con=1 for 2 cycles -> 9, 10.
- Down: from 10, cup=0, con=1 for 3 cycles -> 9, 8, 7.
- Load priority: from 7, load=1, cup=1, con=1, data_in=1 for one edge -> data_out=1. Then load=0 for 7 edges -> 2,3,...,8.
- Wrap both ways:
  - Load 4'hE, count up -> F, 0, 1.
  - Load 4'h1, count down -> 0, F, E.
  - Load with con=0 still loads.
- Async reset mid-operation: at count 5, drop rst between clock edges -> data_out=0 before the next edge. Hold it low across edges -> stays 0.

Source files
------------

// File: rtl/contador.sv
// ---------------------------------------------------------------------------
// contador: loadable up/down binary counter with count enable.
//
// Ports:
//   clk      - system clock, state updates on rising edge
//   rst      - asynchronous active-low reset, clears the count immediately
//   data_in  - parallel load value
//   load     - synchronous load request (highest priority)
//   con      - count enable; 0 holds the current value
//   cup      - count direction; 1 = up, 0 = down
//   data_out - current count, driven straight from the state register
// ---------------------------------------------------------------------------
module contador #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load,
   input  logic             con,
   input  logic             cup,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_nxt;

   // Next-count selection: load beats counting; arithmetic wraps modulo 2^WIDTH.
   always_comb begin
      count_nxt = count_q;
      if (load) begin
         count_nxt = data_in;
      end else if (con) begin
         if (cup) begin
            count_nxt = count_q + WIDTH'(1);
         end else begin
            count_nxt = count_q - WIDTH'(1);
         end
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_nxt;
      end
   end

   assign data_out = count_q;

endmodule

// File: tb/tb_contador.sv
// ---------------------------------------------------------------------------
// tb_contador: directed self-checking bench for contador (WIDTH = 4).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. just after the edge that produced them.
// ---------------------------------------------------------------------------
module tb_contador;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] data_in;
   logic             load;
   logic             con;
   logic             cup;
   logic [WIDTH-1:0] data_out;

   int unsigned pass_cnt;
   int unsigned total_cnt;

   contador #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .data_in  (data_in),
      .load     (load),
      .con      (con),
      .cup      (cup),
      .data_out (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got %0d checks of %0d passed, required completion", pass_cnt, total_cnt);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst     = 1'b0;
      data_in = 4'h1;
      load    = 1'b0;
      con     = 1'b1;
      cup     = 1'b1;
      #1;
      total_cnt++;
      if (data_out !== 4'h0) $display("FAIL reset_initial: got %h, required %h", data_out, 4'h0);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (data_out !== 4'h0) $display("FAIL reset_held: got %h, required %h", data_out, 4'h0);
      else pass_cnt++;
      rst = 1'b1;
   endtask

   task automatic test_up();
      logic [WIDTH-1:0] exp;
      for (int i = 1; i <= 8; i++) begin
         tick();
         exp = WIDTH'(i);
         total_cnt++;
         if (data_out !== exp) $display("FAIL up_step%0d: got %h, required %h", i, data_out, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_pause();
      logic [WIDTH-1:0] exp;
      con = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if (data_out !== 4'h8) $display("FAIL pause_hold%0d: got %h, required %h", i, data_out, 4'h8);
         else pass_cnt++;
      end
      con = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         exp = WIDTH'(9 + i);
         total_cnt++;
         if (data_out !== exp) $display("FAIL pause_resume%0d: got %h, required %h", i, data_out, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_down();
      logic [WIDTH-1:0] exp;
      cup = 1'b0;
      con = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp = WIDTH'(9 - i);
         total_cnt++;
         if (data_out !== exp) $display("FAIL down_step%0d: got %h, required %h", i, data_out, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_load_priority();
      logic [WIDTH-1:0] exp;
      load    = 1'b1;
      cup     = 1'b1;
      con     = 1'b1;
      data_in = 4'h1;
      tick();
      total_cnt++;
      if (data_out !== 4'h1) $display("FAIL load_priority: got %h, required %h", data_out, 4'h1);
      else pass_cnt++;
      load = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         exp = WIDTH'(2 + i);
         total_cnt++;
         if (data_out !== exp) $display("FAIL load_then_up%0d: got %h, required %h", i, data_out, exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap_up();
      logic [WIDTH-1:0] exp_seq [3];
      exp_seq[0] = 4'hF;
      exp_seq[1] = 4'h0;
      exp_seq[2] = 4'h1;
      load    = 1'b1;
      data_in = 4'hE;
      cup     = 1'b1;
      con     = 1'b1;
      tick();
      total_cnt++;
      if (data_out !== 4'hE) $display("FAIL wrap_up_load: got %h, required %h", data_out, 4'hE);
      else pass_cnt++;
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if (data_out !== exp_seq[i]) $display("FAIL wrap_up%0d: got %h, required %h", i, data_out, exp_seq[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_wrap_down();
      logic [WIDTH-1:0] exp_seq [3];
      exp_seq[0] = 4'h0;
      exp_seq[1] = 4'hF;
      exp_seq[2] = 4'hE;
      load    = 1'b1;
      data_in = 4'h1;
      cup     = 1'b0;
      con     = 1'b1;
      tick();
      total_cnt++;
      if (data_out !== 4'h1) $display("FAIL wrap_down_load: got %h, required %h", data_out, 4'h1);
      else pass_cnt++;
      load = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if (data_out !== exp_seq[i]) $display("FAIL wrap_down%0d: got %h, required %h", i, data_out, exp_seq[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_load_disabled();
      con     = 1'b0;
      load    = 1'b1;
      data_in = 4'hA;
      tick();
      total_cnt++;
      if (data_out !== 4'hA) $display("FAIL load_con0: got %h, required %h", data_out, 4'hA);
      else pass_cnt++;
      load = 1'b0;
      tick();
      total_cnt++;
      if (data_out !== 4'hA) $display("FAIL load_con0_hold: got %h, required %h", data_out, 4'hA);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      load    = 1'b1;
      data_in = 4'h5;
      con     = 1'b1;
      cup     = 1'b1;
      tick();
      load = 1'b0;
      total_cnt++;
      if (data_out !== 4'h5) $display("FAIL async_pre: got %h, required %h", data_out, 4'h5);
      else pass_cnt++;
      // Drop reset mid-cycle, well clear of any rising edge.
      @(negedge clk);
      rst = 1'b0;
      #1;
      total_cnt++;
      if (data_out !== 4'h0) $display("FAIL async_immediate: got %h, required %h", data_out, 4'h0);
      else pass_cnt++;
      tick();
      tick();
      total_cnt++;
      if (data_out !== 4'h0) $display("FAIL async_held: got %h, required %h", data_out, 4'h0);
      else pass_cnt++;
      rst = 1'b1;
      for (int i = 1; i <= 2; i++) begin
         tick();
         total_cnt++;
         if (data_out !== WIDTH'(i)) $display("FAIL async_resume%0d: got %h, required %h", i, data_out, WIDTH'(i));
         else pass_cnt++;
      end
   endtask

   initial begin
      pass_cnt  = 0;
      total_cnt = 0;
      test_reset();
      test_up();
      test_pause();
      test_down();
      test_load_priority();
      test_wrap_up();
      test_wrap_down();
      test_load_disabled();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
